// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline hazard/stall controller.
// The mult/div unit imports the same latency defaults so that the busy
// window seen by the stall logic always matches the real unit latency.
package pipe_stall_ctrl_pkg;

  // Width of the Tuse / Tnew timing fields carried down the pipeline
  localparam int TUSE_W = 2;
  localparam int TNEW_W = 2;

  // A Tuse of 3 means "operand not read"; Tnew never exceeds 2, so it can never stall
  localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

  // Mult/div latencies in cycles after the start is issued in E
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // Width of the optional stall statistics counters
  localparam int STAT_W = 32;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_cnt.sv
// Mult/div busy countdown. A start loads the latency of the selected
// operation (reloading if already busy); the counter then runs down to zero.
// Busy is the registered "counter nonzero" flag, so it rises the cycle after
// the start and stays high for exactly the operation latency.
module md_busy_cnt
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic mdStart_i,
  input  logic mdDiv_i,
  output logic mdBusy_o
);

  logic [CNT_W-1:0] mdCnt_q;
  logic [CNT_W-1:0] mdCnt_d;

  // Next count: a new start wins over the running countdown
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (mdStart_i) begin
      mdCnt_d = mdDiv_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - 1'b1;
    end
  end

  // Counter register; reset aborts any operation in flight
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mdCnt_q <= '0;
    end else begin
      mdCnt_q <= mdCnt_d;
    end
  end

  assign mdBusy_o = (mdCnt_q != '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for the five-stage pipeline.
// Freezes PC and F/D and bubbles D/E whenever the instruction in decode
// would read a register that E or M has not produced in time (Tuse/Tnew),
// or needs the mult/div unit while it is starting or still busy.
// Optional build macro STALL_STAT_EN adds saturating stall statistics
// counters (StallCnt, MdStallCnt).
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [4:0]        RsD,
  input  logic [4:0]        RtD,
  input  logic [TUSE_W-1:0] TuseRsD,
  input  logic [TUSE_W-1:0] TuseRtD,
  input  logic              MdUseD,
  input  logic [4:0]        A3E,
  input  logic [TNEW_W-1:0] TnewE,
  input  logic [4:0]        A3M,
  input  logic [TNEW_W-1:0] TnewM,
  input  logic              MdStartE,
  input  logic              MdDivE,
`ifdef STALL_STAT_EN
  output logic [STAT_W-1:0] StallCnt,
  output logic [STAT_W-1:0] MdStallCnt,
`endif
  output logic              PCEn,
  output logic              DRegEn,
  output logic              ERegClr,
  output logic              MdBusy
);

  logic mdBusyRaw;
  logic stallRs;
  logic stallRt;
  logic stallMd;
  logic stall;

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk_i     (Clk),
    .reset_i   (Reset),
    .mdStart_i (MdStartE),
    .mdDiv_i   (MdDivE),
    .mdBusy_o  (mdBusyRaw)
  );

  // Busy is forced low while reset is held so downstream logic sees a clean idle unit
  assign MdBusy = mdBusyRaw & ~Reset;

  // Data and mult/div hazard detection; E and M are checked independently, $zero never stalls
  always_comb begin
    stallRs = (RsD != 5'd0) &&
              (((RsD == A3E) && (TnewE > TuseRsD)) ||
               ((RsD == A3M) && (TnewM > TuseRsD)));
    stallRt = (RtD != 5'd0) &&
              (((RtD == A3E) && (TnewE > TuseRtD)) ||
               ((RtD == A3M) && (TnewM > TuseRtD)));
    stallMd = MdUseD & (MdStartE | MdBusy);
    stall   = (stallRs | stallRt | stallMd) & ~Reset;
  end

  assign PCEn    = ~stall;
  assign DRegEn  = ~stall;
  assign ERegClr = stall;

`ifdef STALL_STAT_EN
  logic              stallMdCounted;
  logic [STAT_W-1:0] stallCnt_q;
  logic [STAT_W-1:0] stallCnt_d;
  logic [STAT_W-1:0] mdStallCnt_q;
  logic [STAT_W-1:0] mdStallCnt_d;

  // Saturating increments for the two statistics counters
  always_comb begin
    stallMdCounted = stallMd & ~Reset;
    stallCnt_d     = stallCnt_q;
    mdStallCnt_d   = mdStallCnt_q;
    if (stall && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (stallMdCounted && (mdStallCnt_q != '1)) begin
      mdStallCnt_d = mdStallCnt_q + 1'b1;
    end
  end

  // Statistics registers, cleared by reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stallCnt_q   <= '0;
      mdStallCnt_q <= '0;
    end else begin
      stallCnt_q   <= stallCnt_d;
      mdStallCnt_q <= mdStallCnt_d;
    end
  end

  assign StallCnt   = stallCnt_q;
  assign MdStallCnt = mdStallCnt_q;
`endif

endmodule
